// File: rtl/differential_serializer.sv
// rtl/differential_serializer.sv - LSB-first word serializer onto a complementary out_p/out_n pair.
// Optional PRBS7 line pattern with prbs_mode input when DIFFSER_PRBS7_EN is defined.
module differential_serializer #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH/2{2'b01}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
`ifdef DIFFSER_PRBS7_EN
  input  logic             prbs_mode,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_p,
  output logic             out_n,
  output logic             busy,
  output logic [15:0]      underrun_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {OFF, RUN} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sr, sr_d, word;
  logic             p_d, n_d, bit_d, do_load, do_shift, boundary;
  logic [15:0]      uc_d;
`ifdef DIFFSER_PRBS7_EN
  logic [6:0]       lfsr, lfsr_d, lfsr_src;
  logic             prbs_on, prbs_on_d;
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sr_d     = sr;
    p_d      = out_p;
    n_d      = out_n;
    uc_d     = underrun_count;
    in_ready = 1'b0;
    do_load  = 1'b0;
    do_shift = 1'b0;
    bit_d    = 1'b0;
    boundary = (cnt == LAST);
`ifdef DIFFSER_PRBS7_EN
    lfsr_d    = lfsr;
    prbs_on_d = prbs_on;
    lfsr_src  = (state == OFF) ? 7'h7F : lfsr;
`endif

    case (state)
      OFF: begin
        in_ready = enable & ~reset;
        p_d      = 1'b0;
        n_d      = 1'b0;
        do_load  = enable;
      end
      RUN: begin
        in_ready = enable & boundary & ~reset;
        if (!boundary) begin
          do_shift = 1'b1;
        end else if (enable) begin
          do_load = 1'b1;
          if (!in_valid && underrun_count != 16'hFFFF)
            uc_d = underrun_count + 16'd1;
        end else begin
          state_d = OFF;
          cnt_d   = '0;
          p_d     = 1'b0;
          n_d     = 1'b0;
        end
      end
      default: state_d = OFF;
    endcase

`ifdef DIFFSER_PRBS7_EN
    // Pattern mode owns the line: no handshakes and no underrun accounting.
    if (prbs_mode) begin
      in_ready = 1'b0;
      uc_d     = underrun_count;
    end
`endif

    word = (in_valid && in_ready) ? in_data : IDLE_WORD;

    if (do_load) begin
      state_d = RUN;
      cnt_d   = '0;
      sr_d    = word >> 1;
      bit_d   = word[0];
    end
    if (do_shift) begin
      cnt_d = cnt + 1'b1;
      sr_d  = sr >> 1;
      bit_d = sr[0];
    end

`ifdef DIFFSER_PRBS7_EN
    if (state == OFF)
      lfsr_d = 7'h7F;
    if (do_load)
      prbs_on_d = prbs_mode;
    if ((do_load && prbs_mode) || (do_shift && prbs_on)) begin
      bit_d  = lfsr_src[6];
      lfsr_d = {lfsr_src[5:0], lfsr_src[6] ^ lfsr_src[5]};
    end
`endif

    if (do_load || do_shift) begin
      p_d = bit_d;
      n_d = ~bit_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= OFF;
      cnt            <= '0;
      sr             <= '0;
      out_p          <= 1'b0;
      out_n          <= 1'b0;
      underrun_count <= '0;
`ifdef DIFFSER_PRBS7_EN
      lfsr           <= 7'h7F;
      prbs_on        <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      sr             <= sr_d;
      out_p          <= p_d;
      out_n          <= n_d;
      underrun_count <= uc_d;
`ifdef DIFFSER_PRBS7_EN
      lfsr           <= lfsr_d;
      prbs_on        <= prbs_on_d;
`endif
    end
  end

  assign busy = (state == RUN);

endmodule
